// File: rtl/mcb_read_streamer.sv
// Read-side MCB user-port initiator: issues read bursts for one frame and streams
// the returned words through a single output register stage with valid/ready.
module mcb_read_streamer #(
  parameter int BURST_LEN     = 32,
  parameter int FRAME_WORDS   = 76800,
  parameter int RD_FIFO_DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        calib_done,
  input  logic        start,
  input  logic [29:0] base_addr,
  output logic        busy,
  output logic        frame_done,
  output logic        cmd_en,
  output logic [2:0]  cmd_instr,
  output logic [5:0]  cmd_bl,
  output logic [29:0] cmd_byte_addr,
  input  logic        cmd_full,
  output logic        rd_en,
  input  logic [31:0] rd_data,
  input  logic        rd_empty,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int CW = $clog2(FRAME_WORDS + 1);

  typedef enum logic [1:0] {IDLE, WAIT_CAL, ISSUE, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] req_words;
  logic [CW-1:0] acc_words;
  logic [29:0]   base;
  logic [6:0]    outstanding;
  logic [6:0]    len;
  logic          room;
  logic          issue;
  logic          last_burst;
  logic          hs;
  logic          last_hs;

  // Words in the next burst: a full burst, or whatever remains of the frame.
  function automatic logic [6:0] burst_len_f(input logic [CW-1:0] req);
    logic [31:0] remaining;
    remaining = 32'(FRAME_WORDS) - 32'(req);
    if (remaining < 32'(BURST_LEN))
      return 7'(remaining);
    return 7'(BURST_LEN);
  endfunction

  assign cmd_instr  = 3'b001;
  assign len        = burst_len_f(req_words);
  assign room       = (8'(outstanding) + 8'(len)) <= 8'(RD_FIFO_DEPTH);
  // cmd_en is registered, so a back-off cycle after each command lets
  // outstanding and cmd_full reflect that command before the next decision.
  assign issue      = (state == ISSUE) && !cmd_en && !cmd_full && room;
  assign last_burst = (32'(req_words) + 32'(len)) == 32'(FRAME_WORDS);
  assign hs         = out_valid && out_ready;
  assign last_hs    = hs && (acc_words == CW'(FRAME_WORDS - 1));
  assign frame_done = last_hs;
  assign rd_en      = busy && !rd_empty && (!out_valid || out_ready);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start) state_nxt = calib_done ? ISSUE : WAIT_CAL;
      WAIT_CAL: if (calib_done) state_nxt = ISSUE;
      ISSUE:    if (issue && last_burst) state_nxt = DRAIN;
      DRAIN:    if (last_hs) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Command side: burst address/length registers and word accounting
  always_ff @(posedge clk) begin
    if (reset) begin
      busy          <= 1'b0;
      base          <= '0;
      req_words     <= '0;
      acc_words     <= '0;
      outstanding   <= '0;
      cmd_en        <= 1'b0;
      cmd_bl        <= '0;
      cmd_byte_addr <= '0;
    end else begin
      cmd_en <= issue;
      if (state == IDLE && start) begin
        base          <= base_addr;
        cmd_byte_addr <= base_addr;
        req_words     <= '0;
        acc_words     <= '0;
        busy          <= 1'b1;
      end
      if (issue) begin
        cmd_bl        <= 6'(len - 7'd1);
        cmd_byte_addr <= base + (30'(req_words) << 2);
        req_words     <= req_words + CW'(len);
      end
      outstanding <= outstanding + (cmd_en ? ({1'b0, cmd_bl} + 7'd1) : 7'd0)
                     - (rd_en ? 7'd1 : 7'd0);
      if (hs)
        acc_words <= acc_words + CW'(1);
      if (last_hs)
        busy <= 1'b0;
    end
  end

  // Output stage: one register between the read FIFO head and the stream
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (rd_en) begin
        out_data  <= rd_data;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (last_hs)
        out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mcb_read_streamer.sv
// Scoreboard bench for mcb_read_streamer with a behavioural MCB port model
// (command latency of 3 clk, first-word-fall-through read FIFO).
module tb_mcb_read_streamer;

  localparam int BL    = 32;
  localparam int FW    = 200;
  localparam int DEPTH = 64;
  localparam int LIMIT = 6000;

  logic        clk = 1'b0;
  logic        reset, calib_done, start, cmd_full, rd_empty, out_ready;
  logic [29:0] base_addr, cmd_byte_addr;
  logic        busy, frame_done, cmd_en, rd_en, out_valid;
  logic [2:0]  cmd_instr;
  logic [5:0]  cmd_bl;
  logic [31:0] rd_data, out_data;

  always #5 clk = ~clk;

  mcb_read_streamer #(.BURST_LEN(BL), .FRAME_WORDS(FW), .RD_FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .calib_done(calib_done), .start(start),
    .base_addr(base_addr), .busy(busy), .frame_done(frame_done),
    .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl),
    .cmd_byte_addr(cmd_byte_addr), .cmd_full(cmd_full), .rd_en(rd_en),
    .rd_data(rd_data), .rd_empty(rd_empty), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [29:0] addr_at(input logic [29:0] b, input int i);
    return 30'(32'(b) + 32'(i) * 32'd4);
  endfunction

  function automatic logic [31:0] word_at(input logic [29:0] a);
    return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  // Scoreboard: expected commands and stream words for an accepted start
  logic [29:0] exp_addr_q[$];
  logic [5:0]  exp_bl_q[$];
  logic [31:0] exp_word_q[$];

  task automatic push_frame(input logic [29:0] b);
    for (int r = 0; r < FW; r += BL) begin
      int n;
      n = (FW - r < BL) ? FW - r : BL;
      exp_addr_q.push_back(addr_at(b, r));
      exp_bl_q.push_back(6'(n - 1));
    end
    for (int i = 0; i < FW; i++)
      exp_word_q.push_back(word_at(addr_at(b, i)));
  endtask

  // MCB port model
  typedef struct {
    logic [29:0] addr;
    int          len;
    int          due;
  } pend_t;
  pend_t       pend_q[$];
  logic [31:0] rdq[$];
  int          cyc = 0;
  bit          pop_req = 0;
  int          cmd_count = 0;
  int          pop_count = 0;
  int          pops_at_cmd3 = -1;
  int          out_model = 0;
  int          frames_done = 0;
  bit          busy_chk = 0;

  initial begin
    rd_empty = 1'b1;
    rd_data  = 32'hDEAD_BEEF;
    forever begin
      bit take, rst_s;
      @(posedge clk);
      rst_s   = reset;
      take    = pop_req;
      pop_req = 0;
      cyc++;
      #1;
      if (rst_s) begin
        pend_q.delete();
        rdq.delete();
      end else begin
        if (take && rdq.size() > 0) void'(rdq.pop_front());
        while (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
          pend_t p;
          p = pend_q.pop_front();
          for (int k = 0; k < p.len; k++) rdq.push_back(word_at(addr_at(p.addr, k)));
        end
      end
      rd_empty = (rdq.size() == 0);
      rd_data  = (rdq.size() == 0) ? 32'hDEAD_BEEF : rdq[0];
    end
  end

  // Monitor: compares everything the DUT presents against the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (busy_chk) begin
          check("busy_after_frame_done", 64'(busy), 64'd0);
          busy_chk = 0;
        end
        if (out_valid) check("valid_only_when_busy", 64'(busy), 64'd1);
        if (cmd_en) begin
          check("cmd_expected", 64'(exp_addr_q.size() != 0), 64'd1);
          if (exp_addr_q.size() != 0) begin
            check("cmd_byte_addr", 64'(cmd_byte_addr), 64'(exp_addr_q.pop_front()));
            check("cmd_bl", 64'(cmd_bl), 64'(exp_bl_q.pop_front()));
          end
          check("cmd_instr", 64'(cmd_instr), 64'd1);
          pend_q.push_back('{addr: cmd_byte_addr, len: int'(cmd_bl) + 1, due: cyc + 3});
          cmd_count++;
          if (cmd_count == 3) pops_at_cmd3 = pop_count;
          out_model += int'(cmd_bl) + 1;
          check("outstanding_bound", 64'(out_model <= DEPTH), 64'd1);
        end
        if (rd_en) begin
          check("rd_en_nonempty", 64'(rd_empty), 64'd0);
          pop_req = 1;
          pop_count++;
          out_model--;
        end
        if (out_valid && out_ready) begin
          check("word_expected", 64'(exp_word_q.size() != 0), 64'd1);
          if (exp_word_q.size() != 0)
            check("out_data", 64'(out_data), 64'(exp_word_q.pop_front()));
          check("frame_done_on_last", 64'(frame_done), 64'(exp_word_q.size() == 0));
          if (frame_done) begin
            frames_done++;
            busy_chk = 1;
          end
        end else begin
          check("frame_done_needs_hs", 64'(frame_done), 64'd0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [29:0] b);
    check("idle_before_start", 64'(busy), 64'd0);
    cmd_count = 0;
    pop_count = 0;
    pops_at_cmd3 = -1;
    base_addr = b;
    start = 1'b1;
    push_frame(b);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_frame(input bit rnd);
    int f0, n;
    f0 = frames_done;
    n  = 0;
    while (frames_done == f0 && n < LIMIT) begin
      if (rnd) begin
        out_ready = ($urandom_range(3) != 0);
        cmd_full  = ($urandom_range(4) == 0);
        start     = busy && ($urandom_range(40) == 0);
        base_addr = 30'($urandom) & ~30'd3;
      end
      tick();
      n++;
    end
    start = 1'b0;
    out_ready = 1'b1;
    cmd_full = 1'b0;
    check("frame_timeout", 64'(n < LIMIT), 64'd1);
    repeat (3) tick();
    check("cmds_left", 64'(exp_addr_q.size()), 64'd0);
    check("words_left", 64'(exp_word_q.size()), 64'd0);
    check("busy_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    int n;
    bit fd_seen;
    reset = 1'b1; calib_done = 1'b1; start = 1'b0; cmd_full = 1'b0;
    out_ready = 1'b1; base_addr = '0;
    repeat (3) tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_cmd_en", 64'(cmd_en), 64'd0);
    check("rst_rd_en", 64'(rd_en), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    check("rst_cmd_instr", 64'(cmd_instr), 64'd1);
    check("rst_cmd_bl", 64'(cmd_bl), 64'd0);
    check("rst_cmd_addr", 64'(cmd_byte_addr), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    reset = 1'b0;
    tick();

    // Full-speed frame; a start coinciding with frame_done must be ignored
    start_frame(30'h0000_1000);
    fd_seen = 0;
    for (int i = 0; i < LIMIT; i++) begin
      @(negedge clk);
      if (frame_done) begin
        start = 1'b1;
        base_addr = 30'h0222_0000;
        fd_seen = 1;
        break;
      end
    end
    tick();
    start = 1'b0;
    check("frame1_done_seen", 64'(fd_seen), 64'd1);
    repeat (4) tick();
    check("start_at_frame_done_ignored", 64'(busy), 64'd0);
    check("frame1_words_left", 64'(exp_word_q.size()), 64'd0);

    // Command FIFO full after start
    cmd_full = 1'b1;
    start_frame(30'h0004_0000);
    for (int i = 0; i < 10; i++) begin
      check("full_no_cmd", 64'(cmd_en), 64'd0);
      check("full_addr_stable", 64'(cmd_byte_addr), 64'h0004_0000);
      tick();
    end
    cmd_full = 1'b0;
    tick();
    check("cmd_after_full_falls", 64'(cmd_en), 64'd1);
    wait_frame(0);

    // Backpressure caps outstanding at two bursts
    out_ready = 1'b0;
    start_frame(30'h0010_0000);
    repeat (40) tick();
    check("stalled_cmd_count", 64'(cmd_count), 64'd2);
    out_ready = 1'b1;
    n = 0;
    while (cmd_count < 3 && n < 200) begin
      tick();
      n++;
    end
    check("third_cmd_seen", 64'(cmd_count >= 3), 64'd1);
    check("third_cmd_pops_lo", 64'(pops_at_cmd3 >= 32), 64'd1);
    check("third_cmd_pops_hi", 64'(pops_at_cmd3 <= 34), 64'd1);
    wait_frame(0);

    // Start before calibration completes
    calib_done = 1'b0;
    start_frame(30'h0020_0040);
    for (int i = 0; i < 20; i++) begin
      check("precal_busy", 64'(busy), 64'd1);
      check("precal_no_cmd", 64'(cmd_en), 64'd0);
      tick();
    end
    calib_done = 1'b1;
    n = 0;
    while (!cmd_en && n < 5) begin
      tick();
      n++;
    end
    check("cmd_within_2_of_cal", 64'(n <= 2), 64'd1);
    wait_frame(0);

    // Randomized frames, including an address wrap
    start_frame(30'h3FFF_FF80);
    wait_frame(1);
    for (int f = 0; f < 2; f++) begin
      start_frame(30'($urandom) & ~30'd3);
      wait_frame(1);
    end

    // Reset mid-frame, then fetch from a new base
    start_frame(30'h0100_0000);
    for (int i = 0; i < 60; i++) begin
      out_ready = ($urandom_range(3) != 0);
      tick();
    end
    reset = 1'b1;
    tick();
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_cmd_en", 64'(cmd_en), 64'd0);
    check("midrst_rd_en", 64'(rd_en), 64'd0);
    reset = 1'b0;
    out_ready = 1'b1;
    exp_addr_q.delete();
    exp_bl_q.delete();
    exp_word_q.delete();
    out_model = 0;
    busy_chk = 0;
    tick();
    start_frame(30'h0ABC_0000);
    wait_frame(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1);
  end

endmodule

// File: doc/mcb_read_streamer.md
Name: mcb_read_streamer

Overview:
- Read-side initiator for one MCB user port of the DDR2 video RAM controller.
- Takes a frame base address and fetches FRAME_WORDS consecutive 32-bit words by issuing read bursts on the port's command FIFO.
- Pops the port's read FIFO and presents the words as a valid/ready stream to the display/pixel pipeline.
- Runs entirely in the controller user clock domain (clk0 at top level).

Parameters:
- BURST_LEN, 32, words per read command; range 1..64.
- FRAME_WORDS, 76800, total 32-bit words fetched per start (640x480 at 8 bpp).
- RD_FIFO_DEPTH, 64, MCB read FIFO depth in words; bounds outstanding requests.

Ports:
- clk  input  1  user-port clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- calib_done  input  1  controller calibration complete.
- start  input  1  one-cycle request to fetch a frame.
- base_addr  input  30  frame byte address; must be 4-byte aligned; sampled on accepted start.
- busy  output  1  frame fetch in progress.
- frame_done  output  1  one-cycle pulse when the final word is accepted downstream.
- cmd_en  output  1  command FIFO write strobe.
- cmd_instr  output  3  command code; constant 3'b001 (read).
- cmd_bl  output  6  burst length minus one.
- cmd_byte_addr  output  30  burst start byte address.
- cmd_full  input  1  command FIFO full.
- rd_en  output  1  read FIFO pop.
- rd_data  input  32  read FIFO head word; first-word-fall-through, valid while rd_empty=0.
- rd_empty  input  1  read FIFO empty.
- out_data  output  32  stream word.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts when out_valid && out_ready.

Behaviour:
- Reset: all outputs 0 except cmd_instr=3'b001. Internal counters clear and state goes to IDLE. Words already in the MCB read FIFO are not flushed, so the top level resets the controller together with this block.
- Command-side FSM states: IDLE, WAIT_CAL, ISSUE, DRAIN.
  - IDLE: on start, latch base_addr, clear req_words, clear acc_words, set busy. Go to ISSUE if calib_done=1, otherwise WAIT_CAL.
  - WAIT_CAL: go to ISSUE on calib_done=1.
  - ISSUE: compute len = min(BURST_LEN, FRAME_WORDS - req_words). Assert cmd_en for exactly one cycle when cmd_full=0 and outstanding + len <= RD_FIFO_DEPTH, with:
    - cmd_bl = len-1
    - cmd_byte_addr = base + 4*req_words, truncated to 30 bits, wraps silently.
    - Then req_words += len.
    - Go to DRAIN when req_words reaches FRAME_WORDS.
  - DRAIN: wait for the final output handshake, then go to IDLE.
- cmd_byte_addr and cmd_bl are held stable while cmd_en=0.
- outstanding: 7-bit count of words commanded but not yet popped.
  - +len on cmd_en, -1 on rd_en; a simultaneous event applies both in the same cycle.
  - Never exceeds RD_FIFO_DEPTH.
- Pop path, one register stage:
  - rd_en = busy && !rd_empty && (!out_valid || out_ready).
  - On rd_en: out_data <= rd_data, out_valid <= 1.
  - Else if out_ready: out_valid <= 0.
  - Throughput is 1 word/clk when downstream is ready. Latency from rd_data valid to out_valid is 1 clk.
- acc_words increments on each output handshake. On the handshake that takes it to FRAME_WORDS: pulse frame_done, clear busy in the same cycle, and return to IDLE on the next cycle.
- start while busy=1 is ignored. start in the same cycle as frame_done is ignored.
- out_valid is never asserted while busy=0, and rd_en is never asserted when rd_empty=1.
- Word counters are sized ceil(log2(FRAME_WORDS+1)) bits.

Test Plan:
1. FRAME_WORDS=64, BURST_LEN=32, base 0x1000, out_ready=1, cmd_full=0, model returns data 3 clk after command.
   - Required: cmd_en pulses at addr 0x1000 then 0x1080, both with bl=31.
   - Required: 64 output words in order, frame_done one clk after the 64th pop, then busy=0.
2. FRAME_WORDS=40, BURST_LEN=32.
   - Required: second command at base+0x80 with bl=7.
   - Required: exactly 40 output words and one frame_done.
3. cmd_full=1 for 10 clk after start.
   - Required: cmd_en=0 throughout, cmd_byte_addr stable at base.
   - Required: command issues the clk after cmd_full falls.
4. out_ready=0 with FRAME_WORDS=256, BURST_LEN=32.
   - Required: exactly two commands issue (outstanding=64), then no cmd_en.
   - Required: once out_ready=1, the third command issues after the first 32 pops.
5. start with calib_done=0 for 20 clk.
   - Required: busy=1, no cmd_en.
   - Required: first cmd_en within 2 clk of calib_done rising.
6. reset asserted mid-frame.
   - Required: next clk busy=0, out_valid=0, cmd_en=0, rd_en=0.
   - Required: a new start after reset fetches from the new base_addr.
